// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a little-endian byte stream into 32-bit words and
// writes them into the Simple_Single_CPU instruction memory. The CPU is held in
// reset while a program is loading and is released once the last word is in.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   When defined, the load is followed by a 4-byte little-endian checksum
//   (sum modulo 2^32 of all loaded words). A mismatch returns to IDLE with
//   error_o set and the CPU kept in reset. When undefined, error_o is tied 0.
//
// Byte handshake: a byte transfers on a rising clock edge where byte_valid_i
// and byte_ready_o are both 1. byte_ready_o depends only on the loader state,
// never on byte_valid_i, so the producer may hold or drop valid freely.
//
// dbg_state_o exposes the FSM state: 0 IDLE, 1 LOAD, 2 RUN, 3 CHECK.
module instr_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              abort_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [DATA_W-1:0] im_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        dbg_state_o
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_CHECK = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;
`endif

  // Lengths above the memory depth are clamped so no write can wrap around.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         shift_q, shift_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                error_q, error_d;
`endif

  logic                byte_fire;
  logic                start_go;
  logic [23:0]         shift_in;
  logic [DATA_W-1:0]   packed_word;

  // Byte acceptance and start qualification.
  always_comb begin
    byte_ready_o = (state_q == ST_LOAD)
`ifdef LOADER_CHECKSUM_EN
                   || (state_q == ST_CHECK)
`endif
                   ;
    byte_fire    = byte_valid_i && byte_ready_o;
    // A start is honoured only while idle or running; LOAD/CHECK ignore it.
    start_go     = load_start_i && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    packed_word  = {byte_data_i, shift_q};
  end

  // Place the incoming byte into its little-endian lane of the partial word.
  always_comb begin
    shift_in = shift_q;
    case (byte_cnt_q)
      2'd0:    shift_in[7:0]   = byte_data_i;
      2'd1:    shift_in[15:8]  = byte_data_i;
      2'd2:    shift_in[23:16] = byte_data_i;
      default: shift_in        = shift_q;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    error_d    = error_q;
`endif

    case (state_q)
      ST_LOAD: begin
        if (abort_i) begin
          // Abort wins over a same-cycle 4th byte: the partial word is dropped.
          state_d    = ST_IDLE;
          byte_cnt_d = 2'd0;
        end else begin
          if (byte_fire) begin
            if (byte_cnt_q == 2'd3) begin
              we_d       = 1'b1;
              addr_d     = word_cnt_q[ADDR_W-1:0];
              wdata_d    = packed_word;
              word_cnt_d = word_cnt_q + ONE;
              byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
              sum_d      = sum_q + packed_word;
`endif
            end else begin
              shift_d    = shift_in;
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
          // Leave LOAD on the write cycle of the final word. The packer keeps
          // running so a checksum byte taken in this cycle is not lost.
          if (we_q && (word_cnt_q == len_q)) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_RUN;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (abort_i) begin
          state_d    = ST_IDLE;
          byte_cnt_d = 2'd0;
        end else if (byte_fire) begin
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            if (packed_word == sum_q) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_IDLE;
              error_d = 1'b1;
            end
          end else begin
            shift_d    = shift_in;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
`endif
      ST_IDLE: ;
      ST_RUN:  ;
      default: state_d = ST_IDLE;
    endcase

    if (start_go) begin
      len_d      = (load_len_i > MAX_LEN) ? MAX_LEN : load_len_i;
      word_cnt_d = '0;
      byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_d      = '0;
      error_d    = 1'b0;
      state_d    = (load_len_i == '0) ? ST_CHECK : ST_LOAD;
`else
      state_d    = (load_len_i == '0) ? ST_RUN : ST_LOAD;
`endif
    end
  end

  // State and datapath registers; reset clears everything, including the strobe.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      error_q    <= error_d;
`endif
    end
  end

  // Status outputs are decoded straight from the registered state.
  always_comb begin
    im_we_o     = we_q;
    im_addr_o   = addr_q;
    im_wdata_o  = wdata_q;
    cpu_rst_n_o = (state_q == ST_RUN);
    done_o      = (state_q == ST_RUN);
    busy_o      = byte_ready_o;
    dbg_state_o = state_q;
`ifdef LOADER_CHECKSUM_EN
    error_o     = error_q;
`else
    error_o     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader (ADDR_W=8). Inputs are driven 1ns
// after the rising edge; outputs are sampled there or on the falling edge.
module tb_instr_mem_loader;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_CHECK = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        load_start_i = 1'b0;
  logic [8:0]  load_len_i = '0;
  logic        abort_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = '0;
  logic        byte_ready_o;
  logic        im_we_o;
  logic [7:0]  im_addr_o;
  logic [31:0] im_wdata_o;
  logic        cpu_rst_n_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;
  int ready_drops = 0;

  logic [7:0]  log_addr[$];
  logic [31:0] log_data[$];

  instr_mem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_start_i(load_start_i),
    .load_len_i(load_len_i), .abort_i(abort_i), .byte_valid_i(byte_valid_i),
    .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o), .im_we_o(im_we_o),
    .im_addr_o(im_addr_o), .im_wdata_o(im_wdata_o), .cpu_rst_n_o(cpu_rst_n_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Write recorder and ready monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (rst_i && im_we_o) begin
      log_addr.push_back(im_addr_o);
      log_data.push_back(im_wdata_o);
    end
    if (rst_i && busy_o && !byte_ready_o) ready_drops++;
  end

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic log_clear();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic start_load(input logic [8:0] len);
    load_start_i = 1'b1;
    load_len_i   = len;
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   got;
    got = 1'b0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    for (int n = 0; n < 16 && !got; n++) begin
      rdy = byte_ready_o;
      tick();
      got = rdy;
    end
    byte_valid_i = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_byte: byte %h not accepted within 16 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_word_slow(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      byte_valid_i = 1'b0;
      tick();
      send_byte(w[8*k +: 8]);
    end
  endtask

  // Completes a load: sends the checksum when that feature is built in,
  // otherwise waits out the final write cycle.
  task automatic end_load(input logic [31:0] sum);
`ifdef LOADER_CHECKSUM_EN
    send_word(sum);
`else
    if (sum === 32'hxxxxxxxx) $display("note: unknown checksum");
    tick();
`endif
  endtask

  task automatic test_reset();
    #1;
    checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", byte_ready_o); end
    checks++; if (im_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", im_we_o); end
    checks++; if (im_addr_o !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h exp 00", im_addr_o); end
    checks++; if (im_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", im_wdata_o); end
    checks++; if (cpu_rst_n_o !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst_n: got %b exp 0", cpu_rst_n_o); end
    checks++; if ({busy_o, done_o, error_o} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b exp 000", {busy_o, done_o, error_o}); end
    checks++; if (dbg_state_o !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state_o, S_IDLE); end
    tick(); tick();
    rst_i = 1'b1;
    tick();
    checks++; if (dbg_state_o !== S_IDLE || cpu_rst_n_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset: state %0d cpu_rst_n %b exp 0/0", dbg_state_o, cpu_rst_n_o); end
  endtask

  task automatic test_basic();
    log_clear();
    start_load(9'd2);
    checks++; if (dbg_state_o !== S_LOAD) begin errors++; $display("FAIL basic_state_load: got %0d exp %0d", dbg_state_o, S_LOAD); end
    checks++; if (busy_o !== 1'b1 || byte_ready_o !== 1'b1) begin errors++; $display("FAIL basic_busy_ready: got %b%b exp 11", busy_o, byte_ready_o); end
    send_word(32'h00080020);
    send_word(32'h01091022);
    checks++; if (im_we_o !== 1'b1) begin errors++; $display("FAIL basic_we: got %b exp 1", im_we_o); end
    checks++; if (im_addr_o !== 8'd1) begin errors++; $display("FAIL basic_addr1: got %h exp 01", im_addr_o); end
    checks++; if (im_wdata_o !== 32'h01091022) begin errors++; $display("FAIL basic_data1: got %h exp 01091022", im_wdata_o); end
    checks++; if (cpu_rst_n_o !== 1'b0) begin errors++; $display("FAIL basic_cpu_held_in_write: got %b exp 0", cpu_rst_n_o); end
    checks++; if (byte_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_in_write: got %b exp 1", byte_ready_o); end
    end_load(32'h01111042);
    checks++; if (cpu_rst_n_o !== 1'b1 || done_o !== 1'b1) begin errors++; $display("FAIL basic_released: cpu_rst_n %b done %b exp 1/1", cpu_rst_n_o, done_o); end
    checks++; if (busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin errors++; $display("FAIL basic_run_idle: busy %b ready %b exp 0/0", busy_o, byte_ready_o); end
    checks++; if (im_we_o !== 1'b0 || im_wdata_o !== 32'h01091022) begin errors++; $display("FAIL basic_hold: we %b data %h exp 0/01091022", im_we_o, im_wdata_o); end
    tick();
    checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL basic_write_count: got %0d exp 2", log_addr.size()); end
    if (log_addr.size() >= 2) begin
      checks++; if (log_addr[0] !== 8'd0 || log_data[0] !== 32'h00080020) begin errors++; $display("FAIL basic_write0: addr %h data %h exp 00/00080020", log_addr[0], log_data[0]); end
      checks++; if (log_addr[1] !== 8'd1 || log_data[1] !== 32'h01091022) begin errors++; $display("FAIL basic_write1: addr %h data %h exp 01/01091022", log_addr[1], log_data[1]); end
    end
  endtask

  task automatic test_toggle();
    log_clear();
    ready_drops = 0;
    start_load(9'd2);
    checks++; if (cpu_rst_n_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL toggle_restart: cpu_rst_n %b done %b exp 0/0", cpu_rst_n_o, done_o); end
    send_word_slow(32'h00080020);
    send_word_slow(32'h01091022);
    end_load(32'h01111042);
    tick();
    checks++; if (ready_drops !== 0) begin errors++; $display("FAIL toggle_ready_drop: got %0d cycles exp 0", ready_drops); end
    checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL toggle_write_count: got %0d exp 2", log_addr.size()); end
    if (log_addr.size() >= 2) begin
      checks++; if (log_addr[0] !== 8'd0 || log_data[0] !== 32'h00080020 || log_addr[1] !== 8'd1 || log_data[1] !== 32'h01091022) begin errors++; $display("FAIL toggle_writes: %h/%h %h/%h exp 00/00080020 01/01091022", log_addr[0], log_data[0], log_addr[1], log_data[1]); end
    end
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL toggle_done: got %b exp 1", done_o); end
  endtask

  task automatic test_restart();
    log_clear();
    start_load(9'd1);
    checks++; if (cpu_rst_n_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL restart_entry: cpu_rst_n %b done %b busy %b exp 0/0/1", cpu_rst_n_o, done_o, busy_o); end
    send_word(32'hDEADBEEF);
    checks++; if (im_we_o !== 1'b1 || im_addr_o !== 8'd0 || im_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL restart_write: we %b addr %h data %h exp 1/00/deadbeef", im_we_o, im_addr_o, im_wdata_o); end
    end_load(32'hDEADBEEF);
    checks++; if (cpu_rst_n_o !== 1'b1) begin errors++; $display("FAIL restart_release: got %b exp 1", cpu_rst_n_o); end
    tick();
    checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL restart_write_count: got %0d exp 1", log_addr.size()); end
  endtask

  task automatic test_len_max();
    logic [31:0] sum;
    logic [7:0]  b;
    int          bad;
    int          taken;
    log_clear();
    sum = '0;
    start_load(9'd257);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send_word({b, b, b, b});
      sum = sum + {b, b, b, b};
    end
    checks++; if (im_we_o !== 1'b1 || im_addr_o !== 8'hFF) begin errors++; $display("FAIL max_last_write: we %b addr %h exp 1/ff", im_we_o, im_addr_o); end
    end_load(sum);
    checks++; if (done_o !== 1'b1 || dbg_state_o !== S_RUN) begin errors++; $display("FAIL max_run: done %b state %0d exp 1/%0d", done_o, dbg_state_o, S_RUN); end
    taken = 0;
    byte_valid_i = 1'b1;
    byte_data_i  = 8'hEE;
    for (int n = 0; n < 8; n++) begin
      if (byte_ready_o) taken++;
      tick();
    end
    byte_valid_i = 1'b0;
    tick();
    checks++; if (taken !== 0) begin errors++; $display("FAIL max_extra_accept: got %0d bytes exp 0", taken); end
    checks++; if (log_addr.size() !== 256) begin errors++; $display("FAIL max_write_count: got %0d exp 256", log_addr.size()); end
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++) begin
      b = 8'(i);
      if (log_addr[i] !== b || log_data[i] !== {b, b, b, b}) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL max_write_contents: got %0d bad writes exp 0", bad); end
  endtask

  task automatic test_abort();
    log_clear();
    start_load(9'd3);
    send_word(32'hCAFEF00D);
    send_byte(8'h11);
    send_byte(8'h22);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++; if (dbg_state_o !== S_IDLE) begin errors++; $display("FAIL abort_state: got %0d exp %0d", dbg_state_o, S_IDLE); end
    checks++; if (cpu_rst_n_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL abort_status: cpu_rst_n %b busy %b done %b exp 0/0/0", cpu_rst_n_o, busy_o, done_o); end
    repeat (4) tick();
    checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL abort_write_count: got %0d exp 1", log_addr.size()); end
    if (log_addr.size() >= 1) begin
      checks++; if (log_addr[0] !== 8'd0 || log_data[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_write0: addr %h data %h exp 00/cafef00d", log_addr[0], log_data[0]); end
    end
  endtask

  task automatic test_abort_priority();
    log_clear();
    start_load(9'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h04;
    abort_i      = 1'b1;
    tick();
    abort_i      = 1'b0;
    byte_valid_i = 1'b0;
    checks++; if (dbg_state_o !== S_IDLE) begin errors++; $display("FAIL abort_prio_state: got %0d exp %0d", dbg_state_o, S_IDLE); end
    checks++; if (im_we_o !== 1'b0) begin errors++; $display("FAIL abort_prio_we: got %b exp 0", im_we_o); end
    tick();
    checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL abort_prio_write_count: got %0d exp 0", log_addr.size()); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++; if (dbg_state_o !== S_IDLE) begin errors++; $display("FAIL abort_in_idle: got %0d exp %0d", dbg_state_o, S_IDLE); end
  endtask

  task automatic test_len_zero();
    log_clear();
    start_load(9'd0);
`ifdef LOADER_CHECKSUM_EN
    checks++; if (dbg_state_o !== S_CHECK) begin errors++; $display("FAIL len0_check_state: got %0d exp %0d", dbg_state_o, S_CHECK); end
    end_load(32'h0);
`endif
    checks++; if (done_o !== 1'b1 || cpu_rst_n_o !== 1'b1) begin errors++; $display("FAIL len0_run: done %b cpu_rst_n %b exp 1/1", done_o, cpu_rst_n_o); end
    tick();
    checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL len0_writes: got %0d exp 0", log_addr.size()); end
  endtask

  task automatic test_start_ignored();
    log_clear();
    start_load(9'd1);
    start_load(9'd0);
    checks++; if (dbg_state_o !== S_LOAD || cpu_rst_n_o !== 1'b0) begin errors++; $display("FAIL start_in_load: state %0d cpu_rst_n %b exp %0d/0", dbg_state_o, cpu_rst_n_o, S_LOAD); end
    send_word(32'h11223344);
    end_load(32'h11223344);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL start_in_load_done: got %b exp 1", done_o); end
    tick();
    checks++; if (log_data.size() !== 1 || im_wdata_o !== 32'h11223344) begin errors++; $display("FAIL start_in_load_write: count %0d data %h exp 1/11223344", log_data.size(), im_wdata_o); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++; if (dbg_state_o !== S_RUN || done_o !== 1'b1) begin errors++; $display("FAIL abort_in_run: state %0d done %b exp %0d/1", dbg_state_o, done_o, S_RUN); end
  endtask

  task automatic test_async_reset();
    log_clear();
    start_load(9'd2);
    send_word(32'hA1B2C3D4);
    checks++; if (im_we_o !== 1'b1) begin errors++; $display("FAIL areset_pre_we: got %b exp 1", im_we_o); end
    #2;
    rst_i = 1'b0;
    #1;
    checks++; if (im_we_o !== 1'b0 || im_addr_o !== 8'd0 || im_wdata_o !== 32'h0) begin errors++; $display("FAIL areset_outputs: we %b addr %h data %h exp 0/00/0", im_we_o, im_addr_o, im_wdata_o); end
    checks++; if (dbg_state_o !== S_IDLE || busy_o !== 1'b0 || cpu_rst_n_o !== 1'b0) begin errors++; $display("FAIL areset_state: state %0d busy %b cpu_rst_n %b exp 0/0/0", dbg_state_o, busy_o, cpu_rst_n_o); end
    tick();
    rst_i = 1'b1;
    tick();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    start_load(9'd2);
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000003);
    checks++; if (dbg_state_o !== S_RUN || error_o !== 1'b0 || cpu_rst_n_o !== 1'b1) begin errors++; $display("FAIL csum_match: state %0d err %b cpu_rst_n %b exp %0d/0/1", dbg_state_o, error_o, cpu_rst_n_o, S_RUN); end
    start_load(9'd2);
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000004);
    checks++; if (dbg_state_o !== S_IDLE || error_o !== 1'b1 || cpu_rst_n_o !== 1'b0) begin errors++; $display("FAIL csum_mismatch: state %0d err %b cpu_rst_n %b exp 0/1/0", dbg_state_o, error_o, cpu_rst_n_o); end
    repeat (3) tick();
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL csum_error_sticky: got %b exp 1", error_o); end
    start_load(9'd1);
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL csum_error_clear: got %b exp 0", error_o); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_restart();
    test_len_max();
    test_abort();
    test_abort_priority();
    test_len_zero();
    test_start_ignored();
    test_async_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Upstream of Simple_Single_CPU: accepts a byte stream over a valid/ready handshake and packs it into 32-bit instructions.
- Writes those words into the CPU instruction memory, one write port into IM.Instr_Mem.
- Holds the CPU in reset while loading, then releases it. This replaces backdoor memory preloading, so programs can be delivered at run time.

Parameters:
- ADDR_W, 8, instruction-memory word-address width (depth = 2^ADDR_W words).
- DATA_W, 32, instruction word width; fixed at 4 bytes.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- load_start_i  input  1  single-cycle pulse that starts a load.
- load_len_i  input  ADDR_W+1  number of words to load, sampled on the start cycle.
- abort_i  input  1  abandons a load in progress.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- im_we_o  output  1  instruction-memory write strobe.
- im_addr_o  output  ADDR_W  word address.
- im_wdata_o  output  32  instruction word.
- cpu_rst_n_o  output  1  active-low reset to the CPU.
- busy_o  output  1  load in progress.
- done_o  output  1  program loaded, CPU running.
- error_o  output  1  checksum failure (only with the optional feature; tied 0 otherwise).

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State IDLE; all counters 0.
  - byte_ready_o=0, im_we_o=0, im_addr_o=0, im_wdata_o=0.
  - cpu_rst_n_o=0, busy_o=0, done_o=0, error_o=0.
- States: IDLE, LOAD, RUN (plus CHECK with the optional feature).
- IDLE:
  - CPU held in reset.
  - load_start_i with load_len_i=0 -> RUN next cycle.
  - load_start_i with load_len_i>0 -> LOAD. Latch the length, saturated to 2^ADDR_W. Clear word_cnt and byte_cnt.
- LOAD:
  - busy_o=1, byte_ready_o=1.
  - A byte transfers when byte_valid_i and byte_ready_o are both 1.
  - Little-endian packing: the first byte goes to bits[7:0], the fourth to bits[31:24].
  - On the 4th accepted byte, the next cycle gives im_we_o=1 for exactly one cycle, im_addr_o=word_cnt, im_wdata_o=packed word. word_cnt then increments.
  - byte_ready_o stays 1 during the write cycle, so there is no back-pressure bubble.
  - After the write of word load_len-1 -> RUN. No write ever targets an address >= 2^ADDR_W.
- RUN:
  - Entered the cycle after the last write. From that cycle: cpu_rst_n_o=1, done_o=1, busy_o=0, byte_ready_o=0.
  - Bytes presented in RUN are not accepted.
- Restart: load_start_i in RUN -> LOAD. In the next cycle cpu_rst_n_o=0 and done_o=0.
- load_start_i during LOAD is ignored.
- abort_i:
  - In LOAD -> IDLE next cycle. The partial word is discarded with no write; words already written remain in IM; CPU stays in reset.
  - abort_i has priority over a same-cycle 4th byte.
  - abort_i in IDLE or RUN has no effect.
- Reset asserted mid-load returns to IDLE immediately; im_we_o drops asynchronously.
- im_addr_o and im_wdata_o hold their last values when im_we_o=0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, state CHECK accepts 4 more bytes (little-endian): the expected 32-bit sum modulo 2^32 of all loaded words.
  - Match -> RUN, with error_o=0.
  - Mismatch -> IDLE with error_o=1. The CPU stays in reset; error_o stays 1 until the next load_start_i.
  - abort_i in CHECK behaves as in LOAD.
  - load_len_i=0 also requires a checksum of 0.
- Not defined: no CHECK state, no accumulator, error_o tied 0.

Test Plan:
- Reset then start with len=2 and bytes 20 00 08 00, 22 10 09 01 -> im_we_o pulses at addr 0 data 0x00080020, then addr 1 data 0x01091022; cpu_rst_n_o=1 and done_o=1 the cycle after the second write.
- Same load with byte_valid_i toggled every other cycle -> identical writes; byte_ready_o never drops in LOAD.
- Start len=3, abort after word 1 plus 2 bytes -> exactly 1 write (addr 0); state IDLE; cpu_rst_n_o=0; no write to addr 1.
- Start with load_len_i=2^ADDR_W+1 (=257) and stream 257 words -> writes to addrs 0..255 only; RUN after addr 255; the 257th word is never accepted.
- In RUN, pulse load_start_i with len=1 -> cpu_rst_n_o falls the next cycle; new word written at addr 0; CPU released again.
- With LOADER_CHECKSUM_EN: words 0x00000001 and 0x00000002 with checksum 0x00000003 -> RUN; with checksum 0x00000004 -> error_o=1 and cpu_rst_n_o stays 0.
